// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
package rf_pkg;

  localparam int unsigned RfWidth = 32;
  localparam int unsigned RfDepth = 32;
  localparam int unsigned RfAw    = $clog2(RfDepth);

  typedef logic [RfAw-1:0]    rf_addr_t;
  typedef logic [RfWidth-1:0] rf_word_t;

endpackage

// File: rtl/rf_multiport_if.sv
// Read, write and reservation bus of the multi-port register file.
interface rf_multiport_if #(
  parameter int unsigned WIDTH  = rf_pkg::RfWidth,
  parameter int unsigned DEPTH  = rf_pkg::RfDepth,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 2,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned CW     = $clog2(DEPTH + 1)
);

  logic [NREAD-1:0][AW-1:0]     rs;
  logic [NREAD-1:0][WIDTH-1:0]  data;
  logic [NREAD-1:0]             busy;
  logic [NWRITE-1:0]            RegWen;
  logic [NWRITE-1:0][AW-1:0]    rsW;
  logic [NWRITE-1:0][WIDTH-1:0] dataW;
  logic                         rsv_en;
  logic [AW-1:0]                rsv_addr;
  logic [CW-1:0]                pend_cnt;
  logic                         wr_conflict;

  modport master (
    output rs, RegWen, rsW, dataW, rsv_en, rsv_addr,
    input  data, busy, pend_cnt, wr_conflict
  );

  modport slave (
    input  rs, RegWen, rsW, dataW, rsv_en, rsv_addr,
    output data, busy, pend_cnt, wr_conflict
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write bits, pending count and per-read-port busy lookup.
module rf_scoreboard #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREAD-1:0][AW-1:0]  rs,
  input  logic [NWRITE-1:0]         wen,
  input  logic [NWRITE-1:0][AW-1:0] wAddr,
  input  logic                      rsvEn,
  input  logic [AW-1:0]             rsvAddr,
  output logic [NREAD-1:0]          busy,
  output logic [CW-1:0]             pendCnt
);

  logic [DEPTH-1:0] pendQ, pendD, setMask, clrMask;
  logic [CW-1:0]    cntQ, cntD, decCnt;
  logic [NREAD-1:0] wrHit;
  logic             rsvEff;

  assign rsvEff = rsvEn && !((ZERO_REG != 0) && (rsvAddr == '0));

  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (rsvEff) setMask[rsvAddr] = 1'b1;
    for (int j = 0; j < int'(NWRITE); j++) begin
      if (wen[j]) clrMask[wAddr[j]] = 1'b1;
    end
    // A reservation landing on a written register keeps it pending.
    pendD  = (pendQ & ~clrMask) | setMask;
    decCnt = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (pendQ[k] && clrMask[k] && !setMask[k]) decCnt = decCnt + 1'b1;
    end
    cntD = cntQ - decCnt;
    if (|(setMask & ~pendQ)) cntD = cntD + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendQ <= '0;
      cntQ  <= '0;
    end else begin
      pendQ <= pendD;
      cntQ  <= cntD;
    end
  end

  always_comb begin
    wrHit = '0;
    busy  = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      busy[i] = pendQ[rs[i]];
      if (BYPASS != 0) begin
        for (int j = 0; j < int'(NWRITE); j++) begin
          if (wen[j] && (wAddr[j] == rs[i])) wrHit[i] = 1'b1;
        end
        if (wrHit[i] && !(rsvEff && (rsvAddr == rs[i]))) busy[i] = 1'b0;
      end
    end
  end

  assign pendCnt = cntQ;

endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file with write priority, bypass, zero register and scoreboard.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH    = RfWidth,
  parameter int unsigned DEPTH    = RfDepth,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  rf_multiport_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]             regsQ [DEPTH];
  logic [NWRITE-1:0]            wenEff;
  logic [NREAD-1:0][WIDTH-1:0]  rdData;
  logic                         conflict, wrConflictQ;
  logic [NREAD-1:0]             busyC;
  logic [CW-1:0]                pendCnt;

  always_comb begin
    wenEff = '0;
    for (int j = 0; j < int'(NWRITE); j++) begin
      wenEff[j] = bus.RegWen[j] && !((ZERO_REG != 0) && (bus.rsW[j] == '0));
    end
  end

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) regsQ[k] <= '0;
    end else begin
      for (int j = 0; j < int'(NWRITE); j++) begin
        if (wenEff[j]) regsQ[bus.rsW[j]] <= bus.dataW[j];
      end
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int j = 0; j < int'(NWRITE); j++) begin
      for (int k = j + 1; k < int'(NWRITE); k++) begin
        if (bus.RegWen[j] && bus.RegWen[k] && (bus.rsW[j] == bus.rsW[k])) conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrConflictQ <= 1'b0;
    else        wrConflictQ <= conflict;
  end

  always_comb begin
    rdData = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      rdData[i] = regsQ[bus.rs[i]];
      if (BYPASS != 0) begin
        for (int j = 0; j < int'(NWRITE); j++) begin
          if (bus.RegWen[j] && (bus.rsW[j] == bus.rs[i])) rdData[i] = bus.dataW[j];
        end
      end
      if ((ZERO_REG != 0) && (bus.rs[i] == '0)) rdData[i] = '0;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .NREAD    (NREAD),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .AW       (AW),
    .CW       (CW)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs      (bus.rs),
    .wen     (bus.RegWen),
    .wAddr   (bus.rsW),
    .rsvEn   (bus.rsv_en),
    .rsvAddr (bus.rsv_addr),
    .busy    (busyC),
    .pendCnt (pendCnt)
  );

  assign bus.data        = rdData;
  assign bus.busy        = busyC;
  assign bus.pend_cnt    = pendCnt;
  assign bus.wr_conflict = wrConflictQ;

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard-driven bench for rf_multiport, with a second instance that has bypass disabled.
module tb_rf_multiport;
  import rf_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned passCnt  = 0;
  int unsigned totalCnt = 0;

  rf_word_t expQ [$];
  string    nameQ[$];
  rf_word_t obs  [$];

  rf_multiport_if bus   ();
  rf_multiport_if busNb ();

  rf_multiport u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rf_multiport #(.BYPASS(0)) u_dutNb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busNb)
  );

  always #5 clk = ~clk;

  task automatic want(input string n, input rf_word_t v);
    nameQ.push_back(n);
    expQ.push_back(v);
  endtask

  task automatic idle();
    bus.rs = '0;   bus.RegWen = '0;   bus.rsW = '0;   bus.dataW = '0;
    bus.rsv_en = 1'b0;   bus.rsv_addr = '0;
    busNb.rs = '0; busNb.RegWen = '0; busNb.rsW = '0; busNb.dataW = '0;
    busNb.rsv_en = 1'b0; busNb.rsv_addr = '0;
  endtask

  task automatic test_reset();
    rf_word_t e, o;
    string    n;
    idle();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      bus.rs[0] = rf_addr_t'(a);
      bus.rs[1] = rf_addr_t'(31 - a);
      #1;
      want($sformatf("rst_rd0_x%0d", a), 32'h0);
      obs.push_back(bus.data[0]);
      want($sformatf("rst_rd1_x%0d", 31 - a), 32'h0);
      obs.push_back(bus.data[1]);
    end
    want("rst_pend_cnt", 32'h0);    obs.push_back(rf_word_t'(bus.pend_cnt));
    want("rst_wr_conflict", 32'h0); obs.push_back(rf_word_t'(bus.wr_conflict));
    bus.RegWen[0] = 1'b1; bus.rsW[0] = '0; bus.dataW[0] = 32'hDEADBEEF; bus.rs[0] = '0;
    #1;
    want("x0_same_cycle", 32'h0); obs.push_back(bus.data[0]);
    @(posedge clk); #1;
    @(negedge clk); idle(); #1;
    want("x0_after_write", 32'h0); obs.push_back(bus.data[0]);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); o = obs.pop_front(); totalCnt++;
      if (o !== e) $display("FAIL %s: got %h, want %h", n, o, e);
      else passCnt++;
    end
  endtask

  task automatic test_bypass();
    rf_word_t e, o;
    string    n;
    @(negedge clk); idle();
    bus.RegWen[0] = 1'b1;   bus.rsW[0] = 5'd1;   bus.dataW[0] = 32'h01010101;   bus.rs[0] = 5'd1;
    busNb.RegWen[0] = 1'b1; busNb.rsW[0] = 5'd1; busNb.dataW[0] = 32'h01010101; busNb.rs[0] = 5'd1;
    #1;
    want("bypass_same_cycle", 32'h01010101);  obs.push_back(bus.data[0]);
    want("nobypass_same_cycle", 32'h0);       obs.push_back(busNb.data[0]);
    @(posedge clk); #1;
    want("nobypass_after_edge", 32'h01010101); obs.push_back(busNb.data[0]);
    want("bypass_after_edge", 32'h01010101);   obs.push_back(bus.data[0]);
    @(negedge clk); idle(); bus.rs[1] = 5'd1; busNb.rs[1] = 5'd1; #1;
    want("bypass_stored_x1", 32'h01010101);   obs.push_back(bus.data[1]);
    want("nobypass_stored_x1", 32'h01010101); obs.push_back(busNb.data[1]);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); o = obs.pop_front(); totalCnt++;
      if (o !== e) $display("FAIL %s: got %h, want %h", n, o, e);
      else passCnt++;
    end
  endtask

  task automatic test_collision();
    rf_word_t e, o;
    string    n;
    @(negedge clk); idle();
    bus.RegWen = 2'b11; bus.rsW[0] = 5'd5; bus.rsW[1] = 5'd5;
    bus.dataW[0] = 32'hAAAA; bus.dataW[1] = 32'h5555; bus.rs[0] = 5'd5;
    #1;
    want("coll_bypass_winner", 32'h5555); obs.push_back(bus.data[0]);
    want("coll_flag_before", 32'h0);      obs.push_back(rf_word_t'(bus.wr_conflict));
    @(posedge clk); #1;
    want("coll_flag_set", 32'h1);         obs.push_back(rf_word_t'(bus.wr_conflict));
    @(negedge clk); idle(); bus.rs[0] = 5'd5; #1;
    want("coll_stored_x5", 32'h5555);     obs.push_back(bus.data[0]);
    // Distinct addresses on both ports in the cycle right after the collision.
    bus.RegWen = 2'b11; bus.rsW[0] = 5'd6; bus.rsW[1] = 5'd8;
    bus.dataW[0] = 32'h66; bus.dataW[1] = 32'h88;
    @(posedge clk); #1;
    want("coll_flag_one_cycle", 32'h0);   obs.push_back(rf_word_t'(bus.wr_conflict));
    @(negedge clk); idle(); bus.rs[0] = 5'd6; bus.rs[1] = 5'd8; #1;
    want("dual_write_x6", 32'h66);        obs.push_back(bus.data[0]);
    want("dual_write_x8", 32'h88);        obs.push_back(bus.data[1]);
    want("dual_write_no_flag", 32'h0);    obs.push_back(rf_word_t'(bus.wr_conflict));
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); o = obs.pop_front(); totalCnt++;
      if (o !== e) $display("FAIL %s: got %h, want %h", n, o, e);
      else passCnt++;
    end
  endtask

  task automatic test_scoreboard();
    rf_word_t e, o;
    string    n;
    @(negedge clk); idle(); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
    @(posedge clk); #1;
    want("sb_cnt_after_x3", 32'd1); obs.push_back(rf_word_t'(bus.pend_cnt));
    @(negedge clk); idle(); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
    @(posedge clk); #1;
    bus.rs[1] = 5'd3; #1;
    want("sb_cnt_after_x4", 32'd2); obs.push_back(rf_word_t'(bus.pend_cnt));
    want("sb_busy_x3", 32'd1);      obs.push_back(rf_word_t'(bus.busy[1]));
    @(negedge clk); idle();
    bus.RegWen[0] = 1'b1; bus.rsW[0] = 5'd3; bus.dataW[0] = 32'h33; bus.rs[1] = 5'd3; #1;
    want("sb_busy_x3_bypass", 32'd0); obs.push_back(rf_word_t'(bus.busy[1]));
    @(posedge clk); #1;
    want("sb_cnt_after_wr_x3", 32'd1); obs.push_back(rf_word_t'(bus.pend_cnt));
    @(negedge clk); idle(); bus.rs[1] = 5'd3; bus.rs[0] = 5'd4; #1;
    want("sb_busy_x3_clear", 32'd0); obs.push_back(rf_word_t'(bus.busy[1]));
    want("sb_busy_x4_held", 32'd1);  obs.push_back(rf_word_t'(bus.busy[0]));
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
    bus.RegWen[1] = 1'b1; bus.rsW[1] = 5'd4; bus.dataW[1] = 32'h44; #1;
    want("sb_busy_x4_rsv_wr", 32'd1); obs.push_back(rf_word_t'(bus.busy[0]));
    @(posedge clk); #1;
    want("sb_cnt_rsv_wr_x4", 32'd1); obs.push_back(rf_word_t'(bus.pend_cnt));
    @(negedge clk); idle(); bus.rs[0] = 5'd4; #1;
    want("sb_x4_still_busy", 32'd1); obs.push_back(rf_word_t'(bus.busy[0]));
    want("sb_x4_data", 32'h44);      obs.push_back(bus.data[0]);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); o = obs.pop_front(); totalCnt++;
      if (o !== e) $display("FAIL %s: got %h, want %h", n, o, e);
      else passCnt++;
    end
  endtask

  task automatic test_reset_mid();
    rf_word_t e, o;
    string    n;
    @(negedge clk); idle();
    bus.RegWen[0] = 1'b1; bus.rsW[0] = 5'd7; bus.dataW[0] = 32'h1234;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
    @(posedge clk); #1;
    @(negedge clk); idle(); bus.rs[0] = 5'd7; bus.rs[1] = 5'd4; #1;
    want("mid_pre_data_x7", 32'h1234); obs.push_back(bus.data[0]);
    want("mid_pre_busy_x7", 32'd1);    obs.push_back(rf_word_t'(bus.busy[0]));
    want("mid_pre_cnt", 32'd2);        obs.push_back(rf_word_t'(bus.pend_cnt));
    rst_n = 1'b0; #1;
    want("mid_rst_data_x7", 32'h0);    obs.push_back(bus.data[0]);
    want("mid_rst_busy_x7", 32'd0);    obs.push_back(rf_word_t'(bus.busy[0]));
    want("mid_rst_data_x4", 32'h0);    obs.push_back(bus.data[1]);
    want("mid_rst_cnt", 32'd0);        obs.push_back(rf_word_t'(bus.pend_cnt));
    rst_n = 1'b1; #1;
    @(posedge clk); #1;
    want("mid_post_cnt", 32'd0);       obs.push_back(rf_word_t'(bus.pend_cnt));
    want("mid_post_data_x7", 32'h0);   obs.push_back(bus.data[0]);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); o = obs.pop_front(); totalCnt++;
      if (o !== e) $display("FAIL %s: got %h, want %h", n, o, e);
      else passCnt++;
    end
  endtask

  task automatic test_ceiling();
    rf_word_t e, o;
    string    n;
    for (int a = 1; a < 32; a++) begin
      @(negedge clk); idle(); bus.rsv_en = 1'b1; bus.rsv_addr = rf_addr_t'(a);
      @(posedge clk); #1;
      want($sformatf("ceil_cnt_%0d", a), rf_word_t'(a)); obs.push_back(rf_word_t'(bus.pend_cnt));
    end
    @(negedge clk); idle(); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd31;
    @(posedge clk); #1;
    want("ceil_rereserve_x31", 32'd31); obs.push_back(rf_word_t'(bus.pend_cnt));
    @(negedge clk); idle(); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0; bus.rs[0] = 5'd0;
    @(posedge clk); #1;
    want("ceil_rsv_x0_cnt", 32'd31); obs.push_back(rf_word_t'(bus.pend_cnt));
    want("ceil_x0_not_busy", 32'd0); obs.push_back(rf_word_t'(bus.busy[0]));
    @(negedge clk); idle();
    bus.RegWen = 2'b11; bus.rsW[0] = 5'd1; bus.rsW[1] = 5'd2; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd2;
    @(posedge clk); #1;
    want("ceil_clr_x1_keep_x2", 32'd30); obs.push_back(rf_word_t'(bus.pend_cnt));
    @(negedge clk); idle(); bus.RegWen = 2'b11; bus.rsW[0] = 5'd3; bus.rsW[1] = 5'd4;
    @(posedge clk); #1;
    want("ceil_clr_two", 32'd28); obs.push_back(rf_word_t'(bus.pend_cnt));
    @(negedge clk); idle(); bus.RegWen = 2'b11; bus.rsW[0] = 5'd5; bus.rsW[1] = 5'd5;
    @(posedge clk); #1;
    want("ceil_clr_same_addr", 32'd27); obs.push_back(rf_word_t'(bus.pend_cnt));
    want("ceil_clr_conflict", 32'd1);   obs.push_back(rf_word_t'(bus.wr_conflict));
    @(negedge clk); idle(); bus.rs[0] = 5'd2; bus.rs[1] = 5'd1; #1;
    want("ceil_x2_busy", 32'd1); obs.push_back(rf_word_t'(bus.busy[0]));
    want("ceil_x1_free", 32'd0); obs.push_back(rf_word_t'(bus.busy[1]));
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); o = obs.pop_front(); totalCnt++;
      if (o !== e) $display("FAIL %s: got %h, want %h", n, o, e);
      else passCnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_reset_mid();
    test_ceiling();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
